// File: rtl/fila_arbiter.sv
// Two-producer round-robin arbiter feeding a byte queue. Each transfer takes
// three cycles: IDLE (decide), ISSUE (strobe + ack) and SETTLE (occupancy catches up).
module fila_arbiter #(
    parameter int DEPTH       = 8,
    parameter int STALL_LIMIT = 16
) (
    input  logic       clk_1MHz,
    input  logic       reset,
    input  logic       req_a,
    input  logic [7:0] data_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    input  logic [7:0] fila_len_in,
    output logic       enqueue_out,
    output logic [7:0] enq_data_out,
    output logic       ack_a,
    output logic       ack_b,
    output logic       full_out,
    output logic       stall_a_out,
    output logic       stall_b_out,
    output logic [7:0] grant_cnt_a,
    output logic [7:0] grant_cnt_b
);

    localparam int SW = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t         state_r;
    logic           prefer_a_r;
    logic [SW-1:0]  stall_cnt_a_r;
    logic [SW-1:0]  stall_cnt_b_r;
    logic [SW-1:0]  stall_a_nxt_s;
    logic [SW-1:0]  stall_b_nxt_s;
    logic           grant_a_s;
    logic           grant_b_s;

    // Saturating wait counter: clears when the request drops or is acked.
    function automatic logic [SW-1:0] stall_next(input logic [SW-1:0] cnt,
                                                 input logic req,
                                                 input logic ack);
        if (!req || ack) begin
            return {SW{1'b0}};
        end else if (cnt == SW'(STALL_LIMIT)) begin
            return cnt;
        end else begin
            return cnt + SW'(1);
        end
    endfunction

    // Occupancy above DEPTH is treated as full as well.
    assign full_out = (32'(fila_len_in) >= 32'(DEPTH));

    // Grant decision, only taken in IDLE with room in the queue.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == IDLE && !full_out) begin
            if (req_a && req_b) begin
                grant_a_s = prefer_a_r;
                grant_b_s = !prefer_a_r;
            end else begin
                grant_a_s = req_a;
                grant_b_s = req_b;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Next stall counter values.
    always_comb begin
        stall_a_nxt_s = stall_next(stall_cnt_a_r, req_a, ack_a);
        stall_b_nxt_s = stall_next(stall_cnt_b_r, req_b, ack_b);
    end

    // Transfer FSM with registered strobe, acks, data and round-robin pointer.
    always_ff @(posedge clk_1MHz or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            enqueue_out  <= 1'b0;
            ack_a        <= 1'b0;
            ack_b        <= 1'b0;
            enq_data_out <= 8'h00;
            prefer_a_r   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_a_s || grant_b_s) begin
                        state_r      <= ISSUE;
                        enqueue_out  <= 1'b1;
                        ack_a        <= grant_a_s;
                        ack_b        <= grant_b_s;
                        enq_data_out <= grant_a_s ? data_a : data_b;
                        prefer_a_r   <= grant_b_s;
                    end else begin
                        enqueue_out <= 1'b0;
                        ack_a       <= 1'b0;
                        ack_b       <= 1'b0;
                    end
                end
                ISSUE: begin
                    state_r     <= SETTLE;
                    enqueue_out <= 1'b0;
                    ack_a       <= 1'b0;
                    ack_b       <= 1'b0;
                end
                SETTLE: begin
                    state_r     <= IDLE;
                    enqueue_out <= 1'b0;
                    ack_a       <= 1'b0;
                    ack_b       <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    enqueue_out <= 1'b0;
                    ack_a       <= 1'b0;
                    ack_b       <= 1'b0;
                end
            endcase
        end
    end

    // Stall counters and their flags, flag tracks the saturated value.
    always_ff @(posedge clk_1MHz or negedge reset) begin
        if (!reset) begin
            stall_cnt_a_r <= {SW{1'b0}};
            stall_cnt_b_r <= {SW{1'b0}};
            stall_a_out   <= 1'b0;
            stall_b_out   <= 1'b0;
        end else begin
            stall_cnt_a_r <= stall_a_nxt_s;
            stall_cnt_b_r <= stall_b_nxt_s;
            stall_a_out   <= (stall_a_nxt_s == SW'(STALL_LIMIT));
            stall_b_out   <= (stall_b_nxt_s == SW'(STALL_LIMIT));
        end
    end

    // Saturating grant counters, stepped by the ack pulses.
    always_ff @(posedge clk_1MHz or negedge reset) begin
        if (!reset) begin
            grant_cnt_a <= 8'd0;
            grant_cnt_b <= 8'd0;
        end else begin
            if (ack_a && grant_cnt_a != 8'hFF) begin
                grant_cnt_a <= grant_cnt_a + 8'd1;
            end else begin
                grant_cnt_a <= grant_cnt_a;
            end
            if (ack_b && grant_cnt_b != 8'hFF) begin
                grant_cnt_b <= grant_cnt_b + 8'd1;
            end else begin
                grant_cnt_b <= grant_cnt_b;
            end
        end
    end

endmodule

// File: tb/tb_fila_arbiter.sv
// Directed-vector bench for fila_arbiter; outputs are sampled 1ns after each rising edge.
`timescale 1ns/1ps
module tb_fila_arbiter;

    logic       clk_1MHz;
    logic       reset;
    logic       req_a;
    logic [7:0] data_a;
    logic       req_b;
    logic [7:0] data_b;
    logic [7:0] fila_len_in;
    logic       enqueue_out;
    logic [7:0] enq_data_out;
    logic       ack_a;
    logic       ack_b;
    logic       full_out;
    logic       stall_a_out;
    logic       stall_b_out;
    logic [7:0] grant_cnt_a;
    logic [7:0] grant_cnt_b;

    int vec_cnt;
    int err_cnt;

    fila_arbiter #(.DEPTH(8), .STALL_LIMIT(16)) dut (
        .clk_1MHz    (clk_1MHz),
        .reset       (reset),
        .req_a       (req_a),
        .data_a      (data_a),
        .req_b       (req_b),
        .data_b      (data_b),
        .fila_len_in (fila_len_in),
        .enqueue_out (enqueue_out),
        .enq_data_out(enq_data_out),
        .ack_a       (ack_a),
        .ack_b       (ack_b),
        .full_out    (full_out),
        .stall_a_out (stall_a_out),
        .stall_b_out (stall_b_out),
        .grant_cnt_a (grant_cnt_a),
        .grant_cnt_b (grant_cnt_b)
    );

    initial clk_1MHz = 1'b0;
    always #500 clk_1MHz = ~clk_1MHz;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1MHz);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_1MHz);
        reset = 1'b0;
        #200;
        reset = 1'b1;
    endtask

    initial begin
        vec_cnt     = 0;
        err_cnt     = 0;
        reset       = 1'b0;
        req_a       = 1'b0;
        req_b       = 1'b0;
        data_a      = 8'h00;
        data_b      = 8'h00;
        fila_len_in = 8'd0;
        #300;
        check_vec("rst_enq",   {31'd0, enqueue_out}, 32'd0);
        check_vec("rst_ack",   {30'd0, ack_a, ack_b}, 32'd0);
        check_vec("rst_data",  {24'd0, enq_data_out}, 32'h00);
        check_vec("rst_cnt",   {16'd0, grant_cnt_a, grant_cnt_b}, 32'd0);
        check_vec("rst_stall", {30'd0, stall_a_out, stall_b_out}, 32'd0);
        check_vec("rst_full",  {31'd0, full_out}, 32'd0);

        // Single A transfer
        @(negedge clk_1MHz);
        reset  = 1'b1;
        req_a  = 1'b1;
        data_a = 8'hAB;
        tick();
        req_a = 1'b0;
        check_vec("a1_enq",  {31'd0, enqueue_out}, 32'd1);
        check_vec("a1_ack",  {30'd0, ack_a, ack_b}, 32'd2);
        check_vec("a1_data", {24'd0, enq_data_out}, 32'hAB);
        tick();
        check_vec("a1_enq_off", {31'd0, enqueue_out}, 32'd0);
        check_vec("a1_ack_off", {31'd0, ack_a}, 32'd0);
        check_vec("a1_cnt",     {24'd0, grant_cnt_a}, 32'd1);
        check_vec("a1_hold",    {24'd0, enq_data_out}, 32'hAB);
        tick();
        tick();
        check_vec("a1_idle", {31'd0, enqueue_out}, 32'd0);

        // Both requesting: A,B,A,B one per three cycles
        do_reset();
        req_a  = 1'b1;
        req_b  = 1'b1;
        data_a = 8'hA1;
        data_b = 8'hB2;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_vec("rr_ack", {30'd0, ack_a, ack_b}, (i % 2 == 0) ? 32'd2 : 32'd1);
            check_vec("rr_data", {24'd0, enq_data_out}, (i % 2 == 0) ? 32'hA1 : 32'hB2);
            tick();
            check_vec("rr_gap1", {31'd0, enqueue_out}, 32'd0);
            tick();
            check_vec("rr_gap2", {31'd0, enqueue_out}, 32'd0);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        check_vec("rr_cnt", {16'd0, grant_cnt_a, grant_cnt_b}, 32'h0202);

        // Full queue blocks A and raises the stall flag
        do_reset();
        fila_len_in = 8'd9;
        #1;
        check_vec("full_over", {31'd0, full_out}, 32'd1);
        fila_len_in = 8'd8;
        req_a  = 1'b1;
        data_a = 8'h5A;
        #1;
        check_vec("full_eq", {31'd0, full_out}, 32'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            check_vec("full_noenq", {31'd0, enqueue_out}, 32'd0);
        end
        check_vec("stall_15", {31'd0, stall_a_out}, 32'd0);
        tick();
        check_vec("stall_16", {31'd0, stall_a_out}, 32'd1);
        check_vec("stall_b",  {31'd0, stall_b_out}, 32'd0);
        fila_len_in = 8'd7;
        #1;
        check_vec("full_off", {31'd0, full_out}, 32'd0);
        tick();
        check_vec("full_grant", {30'd0, enqueue_out, ack_a}, 32'd3);
        check_vec("stall_in_ack", {31'd0, stall_a_out}, 32'd1);
        tick();
        check_vec("stall_clr", {31'd0, stall_a_out}, 32'd0);
        req_a       = 1'b0;
        fila_len_in = 8'd0;
        tick();
        tick();

        // Data latched at the grant edge
        req_a  = 1'b1;
        data_a = 8'h11;
        tick();
        data_a = 8'h22;
        req_a  = 1'b0;
        check_vec("latch_issue", {24'd0, enq_data_out}, 32'h11);
        tick();
        check_vec("latch_hold", {24'd0, enq_data_out}, 32'h11);
        tick();

        // Reset during ISSUE aborts and re-arms the pointer to A
        do_reset();
        req_a  = 1'b1;
        data_a = 8'hC3;
        data_b = 8'hD4;
        tick();
        check_vec("abort_pre", {31'd0, ack_a}, 32'd1);
        req_b = 1'b1;
        #100;
        reset = 1'b0;
        #1;
        check_vec("abort_enq", {31'd0, enqueue_out}, 32'd0);
        check_vec("abort_ack", {30'd0, ack_a, ack_b}, 32'd0);
        check_vec("abort_cnt", {24'd0, grant_cnt_a}, 32'd0);
        #100;
        reset = 1'b1;
        tick();
        check_vec("abort_ptr", {30'd0, ack_a, ack_b}, 32'd2);
        req_a = 1'b0;
        req_b = 1'b0;

        // Grant counter saturation
        do_reset();
        req_a = 1'b1;
        repeat (900) tick();
        req_a = 1'b0;
        check_vec("sat_a", {24'd0, grant_cnt_a}, 32'd255);
        check_vec("sat_b", {24'd0, grant_cnt_b}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fila_arbiter.md
FILA_ARBITER -- requirements
Module: fila_arbiter

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, meaning queue capacity in bytes.
REQ-002 The module SHALL have parameter STALL_LIMIT, default 16, meaning wait cycles before a stall flag is raised.
REQ-003 The module SHALL have port clk_1MHz  input  1  single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port req_a  input  1  producer A holds high while data_a is valid.
REQ-006 The module SHALL have port data_a  input  8  producer A byte.
REQ-007 The module SHALL have port req_b  input  1  producer B holds high while data_b is valid.
REQ-008 The module SHALL have port data_b  input  8  producer B byte.
REQ-009 The module SHALL have port fila_len_in  input  8  current queue occupancy.
REQ-010 The module SHALL have port enqueue_out  output  1  one-cycle write strobe to the queue.
REQ-011 The module SHALL have port enq_data_out  output  8  byte written with enqueue_out.
REQ-012 The module SHALL have port ack_a  output  1  one-cycle pulse, A byte accepted.
REQ-013 The module SHALL have port ack_b  output  1  one-cycle pulse, B byte accepted.
REQ-014 The module SHALL have port full_out  output  1  high when fila_len_in >= DEPTH (combinational).
REQ-015 The module SHALL have port stall_a_out  output  1  A waiting >= STALL_LIMIT cycles.
REQ-016 The module SHALL have port stall_b_out  output  1  B waiting >= STALL_LIMIT cycles.
REQ-017 The module SHALL have port grant_cnt_a  output  8  saturating count of A grants.
REQ-018 The module SHALL have port grant_cnt_b  output  8  saturating count of B grants.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, SETTLE; IDLE -> ISSUE on grant, ISSUE -> SETTLE always, SETTLE -> IDLE always.
REQ-020 In IDLE with full_out low, a grant SHALL go to the only requester when one req is high, and to the requester other than the last-granted one when both are high.
REQ-021 The round-robin pointer SHALL update only on a grant and SHALL favour A after reset.
REQ-022 At the grant edge, the winner's data byte SHALL be latched; later changes on data_x SHALL not affect enq_data_out.
REQ-023 During ISSUE, the module SHALL drive enqueue_out=1, the winner's ack=1, and enq_data_out=the latched byte, each for exactly one cycle.
REQ-024 Outputs enqueue_out and ack_x SHALL be registered; they SHALL go high exactly one cycle after the grant edge.
REQ-025 Requests SHALL be ignored in ISSUE and SETTLE; throughput is at most one byte per 3 cycles.
REQ-026 A req still high on return to IDLE SHALL be treated as a new byte.
REQ-027 While full_out is high, no grant SHALL occur; fila_len_in > DEPTH SHALL be treated as full.
REQ-028 Full is sampled only in IDLE; SETTLE guarantees fila_len_in reflects the previous enqueue before the next decision.
REQ-029 Each stall counter SHALL increment per cycle while its req is high and not being acked, clear on ack or req low, and saturate at STALL_LIMIT.
REQ-030 stall_x_out SHALL be high while the counter equals STALL_LIMIT, and SHALL drop the cycle after ack or after req goes low.
REQ-031 grant_cnt_x SHALL increment on each ack_x pulse and saturate at 255.
REQ-032 enq_data_out SHALL hold its last value outside ISSUE.

Reset
REQ-033 While reset=0, the module SHALL clear immediately: state=IDLE, enqueue_out=0, ack_a=0, ack_b=0, enq_data_out=0x00, stall flags and counters=0, grant counts=0, pointer=A.
REQ-034 Reset asserted during ISSUE or SETTLE SHALL abort the transfer with no further strobe or ack; the aborted grant SHALL not be counted if its ack has not yet been issued.
REQ-035 The first grant after reset release SHALL need req sampled in IDLE on the first rising edge with reset=1.

Verification
REQ-036 req_a=1, data_a=0xAB, fila_len_in=0 -> enqueue_out and ack_a high for one cycle with enq_data_out=0xAB, one cycle after the grant edge; grant_cnt_a=1.
REQ-037 req_a and req_b both held, fila_len_in=0 -> grants alternate A,B,A,B, one every 3 cycles, starting with A after reset.
REQ-038 fila_len_in=8, req_a held -> no enqueue_out; stall_a_out=1 after 16 cycles; fila_len_in set to 7 -> A granted and stall_a_out low the cycle after ack.
REQ-039 reset driven low during ISSUE -> enqueue_out, ack_a and ack_b go 0 without a clock edge; after release, pointer favours A.
REQ-040 300 consecutive A grants -> grant_cnt_a=255 and grant_cnt_b=0.
REQ-041 data_a changed from 0x11 to 0x22 in the cycle after the grant edge -> enq_data_out=0x11.
